// File: rtl/mod4_step_scheduler_pkg.sv
// Shared definitions for the mod-4 step scheduler: state width, FSM encoding
// and the step-counter state constants.
package mod4_step_scheduler_pkg;

    localparam int SW = 2;

    typedef logic [SW-1:0] step_t;

    localparam step_t S0 = 2'd0;
    localparam step_t S1 = 2'd1;
    localparam step_t S2 = 2'd2;
    localparam step_t S3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/mod4_step_scheduler_if.sv
// Request/grant bundle between the two requesters and the step scheduler,
// including the advance pulse and shadow state seen by the step counter.
interface mod4_step_scheduler_if;
    import mod4_step_scheduler_pkg::*;

    logic [1:0] req;
    step_t      tgt0;
    step_t      tgt1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       x;
    step_t      cur_state;
    logic       busy;

    modport master (
        output req, tgt0, tgt1,
        input  gnt, done, x, cur_state, busy
    );

    modport slave (
        input  req, tgt0, tgt1,
        output gnt, done, x, cur_state, busy
    );

endinterface

// File: rtl/mod4_step_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: when both request, the one not served last wins.
// Reset leaves the pointer on requester 1 so requester 0 is favoured first.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    logic last_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= served;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req[gi] & (!req[1-gi] || (last_reg != 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/mod4_step_scheduler.sv
// Arbitrates two requesters for a shared mod-4 step counter and pulses x once
// per step until the shadow state reaches the granted requester's target.
module mod4_step_scheduler
    import mod4_step_scheduler_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mod4_step_scheduler_if.slave   bus
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    sched_state_t  state_reg;
    step_t         steps_reg;
    step_t         cur_reg;
    logic [1:0]    gnt_reg;
    logic [1:0]    done_reg;
    logic          x_reg;
    logic [GW-1:0] gap_cnt_reg;

    logic [1:0]    arb_grant;
    step_t         sel_tgt;
    step_t         steps_init;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req),
        .update (state_reg == ST_DONE),
        .served (gnt_reg[1]),
        .grant  (arb_grant)
    );

    // Forward-only distance: a target one behind the current state costs 3 steps.
    assign sel_tgt    = arb_grant[1] ? bus.tgt1 : bus.tgt0;
    assign steps_init = sel_tgt - cur_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            steps_reg   <= S0;
            cur_reg     <= S0;
            gnt_reg     <= 2'b00;
            done_reg    <= 2'b00;
            x_reg       <= 1'b0;
            gap_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_reg <= arb_grant;
                        if (steps_init == S0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= arb_grant;
                        end else begin
                            state_reg <= ST_STEP;
                            steps_reg <= steps_init;
                            x_reg     <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    cur_reg   <= cur_reg + step_t'(1);
                    steps_reg <= steps_reg - step_t'(1);
                    if (steps_reg == step_t'(1)) begin
                        state_reg <= ST_DONE;
                        x_reg     <= 1'b0;
                        done_reg  <= gnt_reg;
                    end else if (GAP > 0) begin
                        state_reg   <= ST_GAP;
                        x_reg       <= 1'b0;
                        gap_cnt_reg <= GAP_LOAD;
                    end else begin
                        x_reg <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg <= ST_STEP;
                        x_reg     <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= 2'b00;
                    done_reg  <= 2'b00;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.done      = done_reg;
    assign bus.x         = x_reg;
    assign bus.cur_state = cur_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mod4_step_scheduler.sv
// Directed bench for mod4_step_scheduler: one instance with GAP=1, one with GAP=0,
// each feeding a behavioural mod-4 step counter to confirm the shadow state.
module tb_mod4_step_scheduler;
    import mod4_step_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mod4_step_scheduler_if bus1 ();
    mod4_step_scheduler_if bus0 ();

    mod4_step_scheduler #(.GAP(1)) dut_g1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mod4_step_scheduler #(.GAP(0)) dut_g0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step counters driven only by x; outputs z0 = state[1], z1 = state[0].
    step_t cnt1;
    step_t cnt0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= S0;
            cnt0 <= S0;
        end else begin
            if (bus1.x) cnt1 <= cnt1 + step_t'(1);
            if (bus0.x) cnt0 <= cnt0 + step_t'(1);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Packed observation: {gnt, x, done, busy, cur_state}
    task automatic snap1(input string tag, input logic [1:0] g, input logic xv,
                         input logic [1:0] d, input logic b, input logic [1:0] c);
        chk(tag, {bus1.gnt, bus1.x, bus1.done, bus1.busy, bus1.cur_state}, {g, xv, d, b, c});
        $display("g1 %s gnt=%b x=%b done=%b busy=%b cur=%0d", tag, bus1.gnt, bus1.x,
                 bus1.done, bus1.busy, bus1.cur_state);
    endtask

    task automatic snap0(input string tag, input logic [1:0] g, input logic xv,
                         input logic [1:0] d, input logic b, input logic [1:0] c);
        chk(tag, {bus0.gnt, bus0.x, bus0.done, bus0.busy, bus0.cur_state}, {g, xv, d, b, c});
        $display("g0 %s gnt=%b x=%b done=%b busy=%b cur=%0d", tag, bus0.gnt, bus0.x,
                 bus0.done, bus0.busy, bus0.cur_state);
    endtask

    task automatic cyc1(input string tag, input logic [1:0] g, input logic xv,
                        input logic [1:0] d, input logic b, input logic [1:0] c);
        @(negedge clk);
        snap1(tag, g, xv, d, b, c);
    endtask

    task automatic cyc0(input string tag, input logic [1:0] g, input logic xv,
                        input logic [1:0] d, input logic b, input logic [1:0] c);
        @(negedge clk);
        snap0(tag, g, xv, d, b, c);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus1.req = 2'b00; bus1.tgt0 = S0; bus1.tgt1 = S0;
        bus0.req = 2'b00; bus0.tgt0 = S0; bus0.tgt1 = S0;

        // Reset state
        @(negedge clk);
        snap1("rst", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        snap0("rst", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        rst_n = 1'b1;

        // GAP=1: requester 0 to state 2, pulses at E0 and E0+2, done at E0+3
        bus1.req = 2'b01; bus1.tgt0 = S2;
        cyc1("t1_c0", 2'b01, 1'b1, 2'b00, 1'b1, S0);
        cyc1("t1_c1", 2'b01, 1'b0, 2'b00, 1'b1, S1);
        cyc1("t1_c2", 2'b01, 1'b1, 2'b00, 1'b1, S1);
        cyc1("t1_c3", 2'b01, 1'b0, 2'b01, 1'b1, S2);
        bus1.req = 2'b00;
        cyc1("t1_idle", 2'b00, 1'b0, 2'b00, 1'b0, S2);
        chk("t1_z0z1", {6'd0, cnt1[1], cnt1[0]}, 8'b10);

        // GAP=0: bring to state 2, then requester 1 to state 1 with 3 back-to-back pulses
        bus0.req = 2'b01; bus0.tgt0 = S2;
        cyc0("t2a_c0", 2'b01, 1'b1, 2'b00, 1'b1, S0);
        cyc0("t2a_c1", 2'b01, 1'b1, 2'b00, 1'b1, S1);
        cyc0("t2a_c2", 2'b01, 1'b0, 2'b01, 1'b1, S2);
        bus0.req = 2'b00;
        cyc0("t2a_idle", 2'b00, 1'b0, 2'b00, 1'b0, S2);
        bus0.req = 2'b10; bus0.tgt1 = S1;
        cyc0("t2b_c0", 2'b10, 1'b1, 2'b00, 1'b1, S2);
        bus0.tgt1 = S3;
        cyc0("t2b_c1", 2'b10, 1'b1, 2'b00, 1'b1, S3);
        cyc0("t2b_c2", 2'b10, 1'b1, 2'b00, 1'b1, S0);
        cyc0("t2b_c3", 2'b10, 1'b0, 2'b10, 1'b1, S1);
        bus0.req = 2'b00;
        cyc0("t2b_idle", 2'b00, 1'b0, 2'b00, 1'b0, S1);
        chk("t2_z0z1", {6'd0, cnt0[1], cnt0[0]}, 8'b01);

        // Simultaneous requests after requester 0 served last: 1 first, then 0
        bus1.req = 2'b11; bus1.tgt0 = S3; bus1.tgt1 = S0;
        cyc1("t3a_c0", 2'b10, 1'b1, 2'b00, 1'b1, S2);
        cyc1("t3a_c1", 2'b10, 1'b0, 2'b00, 1'b1, S3);
        cyc1("t3a_c2", 2'b10, 1'b1, 2'b00, 1'b1, S3);
        cyc1("t3a_c3", 2'b10, 1'b0, 2'b10, 1'b1, S0);
        bus1.req = 2'b01;
        cyc1("t3_gapidle", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        cyc1("t3b_c0", 2'b01, 1'b1, 2'b00, 1'b1, S0);
        cyc1("t3b_c1", 2'b01, 1'b0, 2'b00, 1'b1, S1);
        cyc1("t3b_c2", 2'b01, 1'b1, 2'b00, 1'b1, S1);
        cyc1("t3b_c3", 2'b01, 1'b0, 2'b00, 1'b1, S2);
        cyc1("t3b_c4", 2'b01, 1'b1, 2'b00, 1'b1, S2);
        cyc1("t3b_c5", 2'b01, 1'b0, 2'b01, 1'b1, S3);
        bus1.req = 2'b00;
        cyc1("t3_idle", 2'b00, 1'b0, 2'b00, 1'b0, S3);

        // Zero steps: done with the first gnt cycle, busy for one cycle only
        bus1.req = 2'b01; bus1.tgt0 = S3;
        cyc1("t4_c0", 2'b01, 1'b0, 2'b01, 1'b1, S3);
        bus1.req = 2'b00;
        cyc1("t4_idle", 2'b00, 1'b0, 2'b00, 1'b0, S3);

        // req and tgt dropped after grant: operation still completes to state 1
        bus1.req = 2'b01; bus1.tgt0 = S1;
        cyc1("t6_c0", 2'b01, 1'b1, 2'b00, 1'b1, S3);
        bus1.req = 2'b00; bus1.tgt0 = S0;
        cyc1("t6_c1", 2'b01, 1'b0, 2'b00, 1'b1, S0);
        cyc1("t6_c2", 2'b01, 1'b1, 2'b00, 1'b1, S0);
        cyc1("t6_c3", 2'b01, 1'b0, 2'b01, 1'b1, S1);
        cyc1("t6_idle", 2'b00, 1'b0, 2'b00, 1'b0, S1);

        // Reset during GAP of a 3-step operation
        bus1.req = 2'b01; bus1.tgt0 = S0;
        cyc1("t5_c0", 2'b01, 1'b1, 2'b00, 1'b1, S1);
        cyc1("t5_gap", 2'b01, 1'b0, 2'b00, 1'b1, S2);
        rst_n = 1'b0; bus1.req = 2'b00;
        #1;
        snap1("t5_rst_now", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        snap0("t5_rst_g0", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        cyc1("t5_rst_hold", 2'b00, 1'b0, 2'b00, 1'b0, S0);
        rst_n = 1'b1;
        bus1.req = 2'b10; bus1.tgt1 = S2;
        cyc1("t5r_c0", 2'b10, 1'b1, 2'b00, 1'b1, S0);
        cyc1("t5r_c1", 2'b10, 1'b0, 2'b00, 1'b1, S1);
        cyc1("t5r_c2", 2'b10, 1'b1, 2'b00, 1'b1, S1);
        cyc1("t5r_c3", 2'b10, 1'b0, 2'b10, 1'b1, S2);
        bus1.req = 2'b00;
        cyc1("t5r_idle", 2'b00, 1'b0, 2'b00, 1'b0, S2);
        chk("t5_z0z1", {6'd0, cnt1[1], cnt1[0]}, 8'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod4_step_scheduler.md
Name: mod4_step_scheduler

Overview:
Shares a 2-bit mod-4 step counter (advance input x, outputs z0/z1) between two requesters. Each requester asks for a target state; the scheduler arbitrates round-robin and issues single-cycle advance pulses on x until the counter reaches the target. It keeps a shadow copy of the counter state and signals completion per requester. It sits directly in front of the step counter and is the only driver of its x input.

Parameters:
- SW, 2, state width; the counter wraps mod 2**SW. Only 2 is supported.
- GAP, 1, idle cycles with x=0 between consecutive advance pulses; 0 is legal and means back-to-back pulses.

Ports:
- clk  in  1  single clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  request per requester; hold high until the matching done
- tgt0  in  SW  target state for requester 0; sampled at grant
- tgt1  in  SW  target state for requester 1; sampled at grant
- gnt  out  2  one-hot grant, held for the whole operation
- done  out  2  one-cycle completion pulse to the granted requester
- x  out  1  advance pulse to the step counter, one cycle high per step
- cur_state  out  SW  shadow of the counter state
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, gnt=0, done=0, x=0, cur_state=0, busy=0, priority pointer favours requester 0. The counter's state register must be brought to 0 by the same reset so the shadow matches it.
- FSM states: IDLE, STEP, GAP, DONE.
- IDLE:
  - If req != 0, grant one requester. When both request, the one not served last wins.
  - On that edge: gnt[i]<=1, latch tgt_i, steps <= (tgt_i - cur_state) mod 4 (2-bit wrapping subtract).
  - steps==0 -> DONE; otherwise -> STEP.
- STEP (exactly one cycle):
  - x=1.
  - At the edge: cur_state <= cur_state+1 mod 4 (3->0), steps <= steps-1.
  - If steps was 1 -> DONE; else if GAP>0 -> GAP; else stay in STEP (next pulse immediately).
- GAP: x=0 for exactly GAP cycles (counter), then -> STEP.
- DONE (one cycle):
  - done[i]=1 and gnt[i] still 1.
  - At the edge: gnt<=0, pointer <= i, -> IDLE.
  - A new grant can be issued no earlier than the edge after leaving DONE, so there is always at least one IDLE cycle between operations.
- Timing: with gnt rising at edge E0 and k steps:
  - x is high in the cycles starting at E0 + n*(1+GAP), for n = 0..k-1.
  - done is high in the cycle starting at E0 + k + (k-1)*GAP.
  - For k=0, done is high in the cycle starting at E0.
- Boundaries:
  - Dropping req mid-operation is ignored; the operation completes and done still pulses.
  - Changing tgt after grant has no effect.
  - Max steps is 3 (target = cur-1 wraps forward; never moves backward).
  - Simultaneous requests arriving while busy wait in IDLE arbitration.
- Reset asserted mid-operation: immediate return to the reset values. No done pulse is issued and x drops at once.
- busy = (state != IDLE). x is driven from a register, so it is glitch-free.

Decomposition:
- Shared package: SW, state encodings (IDLE/STEP/GAP/DONE), and the step-state constants S0..S3 = 0..3 reused by the counter.
- Natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a last-served pointer. The FSM, shadow counter and gap counter stay in mod4_step_scheduler.

Test Plan:
- Reset release, req=01, tgt0=2, GAP=1 -> gnt=01 at E0; x high at E0 and E0+2; done=01 at E0+3; cur_state=2; counter outputs z0z1=10.
- From cur_state=2, req=10, tgt1=1, GAP=0 -> 3 back-to-back x pulses (2->3->0->1); done=10 at E0+3; cur_state=1.
- req=11 together, tgt0=3, tgt1=0, last served=0 -> requester 1 granted first; requester 0 granted after one IDLE cycle; done pulses in that order.
- tgt equal to cur_state -> no x pulse; done high in the same cycle gnt first rises; busy high for exactly 1 cycle.
- rst_n driven low during GAP of a 3-step operation -> x=0, gnt=0, cur_state=0 immediately; no done; a fresh request after release is served normally.
- req0 dropped after grant -> operation completes; done[0] still pulses; gnt one-hot throughout (assertion check).
